sa_output_lock: RTL

- Per-output-port switch-allocation stage in the virtual channel router.
- Builds the request vector for its arbiter instance and consumes the resulting grants.
- Once a multi-flit packet wins, it locks the output port to that input until the tail flit has traversed the crossbar (wormhole hold).
- Tracks downstream buffer credits, drives the crossbar select for its output port, and gates all requests while credits are exhausted.

---
 rtl/vr_alloc_pkg.sv | 22 ++
 rtl/arbiter_top.sv | 59 +++++
 rtl/sa_output_lock.sv | 124 ++++++++++++
 3 files changed

// File: rtl/vr_alloc_pkg.sv
// ============================================================================
// Module      : vr_alloc_pkg
// Description : Shared switch-allocation types and helpers for the VC router.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vr_alloc_pkg;

  typedef enum logic [0:0] {
    SA_IDLE   = 1'b0,
    SA_LOCKED = 1'b1
  } sa_state_t;

  // Counter must hold the full depth value, not just depth-1.
  function automatic int cred_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/arbiter_top.sv
// ============================================================================
// Module      : arbiter_top
// Description : Round-robin arbiter; grant is combinational, priority rotates
//               past the winner on every granted cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module arbiter_top #(
  parameter int NUM_REQS = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_REQS-1:0] req,
  output logic [NUM_REQS-1:0] grant
);

  localparam int IDX_W = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;
  localparam int SUM_W = IDX_W + 1;
  localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(NUM_REQS - 1);
  localparam logic [SUM_W-1:0] C_NUM_REQS = SUM_W'(NUM_REQS);

  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] w_gidx;
  logic             w_found;

  always_comb begin
    logic [SUM_W-1:0] v_sum;
    logic [IDX_W-1:0] v_idx;
    grant   = '0;
    w_gidx  = '0;
    w_found = 1'b0;
    v_sum   = '0;
    v_idx   = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      v_sum = {1'b0, r_ptr} + SUM_W'(i);
      if (v_sum >= C_NUM_REQS) begin
        v_sum = v_sum - C_NUM_REQS;
      end
      v_idx = v_sum[IDX_W-1:0];
      if (!w_found && req[v_idx]) begin
        w_found      = 1'b1;
        w_gidx       = v_idx;
        grant[v_idx] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr <= '0;
    end else if (w_found) begin
      r_ptr <= (w_gidx == C_LAST_IDX) ? '0 : w_gidx + IDX_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/sa_output_lock.sv
// ============================================================================
// Module      : sa_output_lock
// Description : Per-output switch allocation with wormhole lock and credits.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sa_output_lock
  import vr_alloc_pkg::*;
#(
  parameter int NUM_REQS    = 3,
  parameter int NUM_CREDITS = 4,
  parameter int CRED_W      = cred_w(NUM_CREDITS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_REQS-1:0] req_valid,
  input  logic [NUM_REQS-1:0] req_tail,
  input  logic                credit_return,
  output logic [NUM_REQS-1:0] xbar_sel,
  output logic                flit_fire,
  output logic                busy,
  output logic [CRED_W-1:0]   credit_count,
  output logic                err_credit_ovf
);

  localparam logic [CRED_W-1:0] C_MAX_CRED = CRED_W'(NUM_CREDITS);
  localparam logic [CRED_W-1:0] C_ONE      = CRED_W'(1);

  sa_state_t           r_state;
  sa_state_t           w_next_state;
  logic [NUM_REQS-1:0] r_owner;
  logic [NUM_REQS-1:0] w_next_owner;
  logic [NUM_REQS-1:0] w_arb_req;
  logic [NUM_REQS-1:0] w_grant;
  logic [NUM_REQS-1:0] w_gq;
  logic                w_has_credit;
  logic                w_tail;

  assign w_has_credit = (credit_count != '0);
  // Held packets present no request so the arbiter's rotation is untouched.
  assign w_arb_req    = (r_state == SA_IDLE && w_has_credit) ? req_valid : '0;
  assign w_gq         = w_grant & w_arb_req;
  assign w_tail       = |(xbar_sel & req_tail);

  arbiter_top #(
    .NUM_REQS (NUM_REQS)
  ) u_arbiter (
    .clk   (clk),
    .reset (reset),
    .req   (w_arb_req),
    .grant (w_grant)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= SA_IDLE;
      r_owner <= '0;
    end else begin
      r_state <= w_next_state;
      r_owner <= w_next_owner;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_owner = r_owner;
    case (r_state)
      SA_IDLE: begin
        if (flit_fire && !w_tail) begin
          w_next_state = SA_LOCKED;
          w_next_owner = xbar_sel;
        end
      end
      SA_LOCKED: begin
        if (flit_fire && w_tail) begin
          w_next_state = SA_IDLE;
          w_next_owner = '0;
        end
      end
      default: begin
        w_next_state = SA_IDLE;
        w_next_owner = '0;
      end
    endcase
  end

  always_comb begin
    xbar_sel = '0;
    if (!reset) begin
      case (r_state)
        SA_IDLE:   xbar_sel = w_gq;
        SA_LOCKED: if (|(r_owner & req_valid) && w_has_credit) xbar_sel = r_owner;
        default:   xbar_sel = '0;
      endcase
    end
    flit_fire = |xbar_sel;
    busy      = (r_state == SA_LOCKED) && !reset;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      credit_count   <= C_MAX_CRED;
      err_credit_ovf <= 1'b0;
    end else begin
      case ({flit_fire, credit_return})
        2'b10: credit_count <= credit_count - C_ONE;
        2'b01: begin
          if (credit_count == C_MAX_CRED) begin
            err_credit_ovf <= 1'b1;
          end else begin
            credit_count <= credit_count + C_ONE;
          end
        end
        default: credit_count <= credit_count;
      endcase
    end
  end

  a_xbar_onehot : assert property (@(posedge clk) disable iff (reset) $onehot0(xbar_sel));

endmodule

`default_nettype wire
